keymask_collector: RTL

Stream-to-bitmask stage that sits directly upstream of the keycode mapper. It consumes the per-report stream of USB HID keyboard usage codes delivered by the USB/NIOS interface, one code per beat. It folds each complete report into the 8-bit action mask the mapper decodes, and publishes the mask only at report boundaries, so the mapper never sees a half-built report.

---
 rtl/keymask_collector.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/keymask_collector.sv
`default_nettype none
// ============================================================================
// Module   : keymask_collector
// Purpose  : Folds a stream of USB HID keyboard usage codes (one code per
//            beat, report framed by key_last) into the 8-bit action mask used
//            by the keycode mapper. The mask is published only at report
//            boundaries; rollover and over-long reports are discarded.
// Ports    : Clk        - system clock
//            Reset      - asynchronous, active-high reset
//            key_valid  - key_code/key_last carry a beat this cycle
//            key_code   - HID usage code [7:0]
//            key_last   - final beat of the current report
//            keycode    - published action mask [7:0]
//            report_stb - one-cycle pulse when keycode is updated
//            report_err - one-cycle pulse when a report is discarded
// Config   : KEYMASK_TIMEOUT_EN - when defined, keycode is forced to 0x00
//            after TIMEOUT_CYCLES cycles without a key_last beat.
// Revision : 1.0 - initial release
// ============================================================================
module keymask_collector #(
   parameter int MAX_KEYS       = 6,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   input  logic       key_last,
   output logic [7:0] keycode,
   output logic       report_stb,
   output logic       report_err
);

   localparam int             CNT_W   = $clog2(MAX_KEYS + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_KEYS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [0:0] {
      S_COLLECT = 1'b0,
      S_DISCARD = 1'b1
   } state_t;

   // A zero or negative timeout makes no sense; nothing is built for it.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
   end

   state_t           state_q;
   logic [7:0]       acc_q;
   logic [7:0]       acc_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [7:0]       keycode_q;
   logic             stb_q;
   logic             err_q;

   logic [7:0]       w_bit;
   logic             w_nz;
   logic             w_err;
   logic             w_last_beat;
   logic             w_timeout;

   // Usage code to action-mask bit; unlisted codes map to nothing.
   always_comb begin
      w_bit = 8'h00;
      case (key_code)
         8'h28:   w_bit = 8'h80; // Enter
         8'h52:   w_bit = 8'h40; // Up
         8'h50:   w_bit = 8'h20; // Left
         8'h4F:   w_bit = 8'h10; // Right
         8'h1A:   w_bit = 8'h04; // W
         8'h04:   w_bit = 8'h02; // A
         8'h07:   w_bit = 8'h01; // D
         default: w_bit = 8'h00;
      endcase
   end

   assign w_nz        = (key_code != 8'h00);
   assign w_last_beat = key_valid & key_last;
   assign acc_d       = acc_q | w_bit;
   assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // Counting this code would push the report past MAX_KEYS, or the host
   // signalled ErrorRollOver.
   assign w_err = (key_code == 8'h01) || (w_nz && (cnt_q >= CNT_LIM));

`ifdef KEYMASK_TIMEOUT_EN
   localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q;
   logic [TMO_W-1:0] tmo_d;

   assign tmo_d = w_last_beat       ? '0 :
                  (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);

   // Fires once, on the edge where the counter reaches TIMEOUT_CYCLES;
   // it then sits saturated so a later report is not wiped again.
   assign w_timeout = !w_last_beat && (tmo_q == TMO_FIRE);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_COLLECT;
         acc_q     <= 8'h00;
         cnt_q     <= '0;
         keycode_q <= 8'h00;
         stb_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         stb_q <= 1'b0;
         err_q <= 1'b0;
         if (w_timeout) begin
            // Stalled link: release every action without a report strobe.
            keycode_q <= 8'h00;
            acc_q     <= 8'h00;
            cnt_q     <= '0;
            state_q   <= S_COLLECT;
         end else if (key_valid) begin
            case (state_q)
               S_COLLECT: begin
                  if (w_err) begin
                     acc_q <= 8'h00;
                     cnt_q <= '0;
                     if (key_last) begin
                        err_q <= 1'b1;
                     end else begin
                        state_q <= S_DISCARD;
                     end
                  end else if (key_last) begin
                     keycode_q <= acc_d;
                     stb_q     <= 1'b1;
                     acc_q     <= 8'h00;
                     cnt_q     <= '0;
                  end else begin
                     acc_q <= acc_d;
                     if (w_nz) begin
                        cnt_q <= cnt_d;
                     end
                  end
               end
               S_DISCARD: begin
                  if (key_last) begin
                     err_q   <= 1'b1;
                     state_q <= S_COLLECT;
                  end
               end
               default: state_q <= S_COLLECT;
            endcase
         end
      end
   end

   assign keycode    = keycode_q;
   assign report_stb = stb_q;
   assign report_err = err_q;

endmodule
`default_nettype wire
